desloca_esq_seq8: RTL and testbench

DESLOCA_ESQ_SEQ8 -- requirements
Module: desloca_esq_seq8

---
 rtl/desloca_esq_seq8_pkg.sv | 14 +
 rtl/desloca_esq_seq8_if.sv | 31 +++
 rtl/desloca_esq8.sv | 16 +
 rtl/desloca_esq_seq8.sv | 96 +++++++++
 tb/tb_desloca_esq_seq8.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/desloca_esq_seq8_pkg.sv
// Shared definitions for the sequential 8-bit left shifter.
// Holds the data and shift-amount widths and the FSM state encoding.
package desloca_esq_seq8_pkg;

    localparam int LARGURA  = 8;
    localparam int LARG_QTD = 3;

    typedef enum logic [1:0] {
        OCIOSO     = 2'b00,
        DESLOCANDO = 2'b01,
        PRONTO     = 2'b10
    } estado_t;

endpackage

// File: rtl/desloca_esq_seq8_if.sv
// Request/result bundle of the sequential left shifter.
//   start     : request pulse, only honoured while the shifter is idle
//   dado      : operand, captured when start is accepted
//   qtd       : shift amount 0..7, captured together with dado
//   resultado : shift register contents, final while done=1
//   vai       : last bit shifted out of bit 7
//   busy      : high whenever the shifter is not idle
//   done      : one-cycle completion strobe
// master = requester, slave = shifter.
interface desloca_esq_seq8_if;
    import desloca_esq_seq8_pkg::*;

    logic                start;
    logic [LARGURA-1:0]  dado;
    logic [LARG_QTD-1:0] qtd;
    logic [LARGURA-1:0]  resultado;
    logic                vai;
    logic                busy;
    logic                done;

    modport master (
        output start, dado, qtd,
        input  resultado, vai, busy, done
    );

    modport slave (
        input  start, dado, qtd,
        output resultado, vai, busy, done
    );

endinterface

// File: rtl/desloca_esq8.sv
// Combinational one-position left shift with zero fill.
//   entrada_i  : value to shift
//   desl_o     : entrada_i shifted left by one, bit 0 = 0
//   bit_fora_o : bit that falls out of the top (entrada_i[7])
module desloca_esq8
    import desloca_esq_seq8_pkg::*;
(
    input  logic [LARGURA-1:0] entrada_i,
    output logic [LARGURA-1:0] desl_o,
    output logic               bit_fora_o
);

    assign desl_o     = {entrada_i[LARGURA-2:0], 1'b0};
    assign bit_fora_o = entrada_i[LARGURA-1];

endmodule

// File: rtl/desloca_esq_seq8.sv
// Sequential left shifter: shifts an 8-bit operand left by qtd positions,
// one position per clock, then strobes done for a single cycle.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of desloca_esq_seq8_if (start/dado/qtd in,
//           resultado/vai/busy/done out)
//
// state      | meaning
// OCIOSO     | idle, waiting for start; resultado/vai hold last result
// DESLOCANDO | one left shift per edge until cnt reaches its last step
// PRONTO     | result final, done=1 for exactly one cycle
module desloca_esq_seq8 #(
    parameter int LARGURA  = 8,
    parameter int LARG_QTD = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    desloca_esq_seq8_if.slave    bus
);
    import desloca_esq_seq8_pkg::*;

    estado_t             estado_q;
    logic [LARGURA-1:0]  resultado_q;
    logic [LARG_QTD-1:0] cnt_q;
    logic                vai_q;
    logic                busy_q;
    logic                done_q;

    logic [LARGURA-1:0]  desl_d;
    logic                bit_fora_d;

    desloca_esq8 u_desloca (
        .entrada_i  (resultado_q),
        .desl_o     (desl_d),
        .bit_fora_o (bit_fora_d)
    );

    // busy/done are registered alongside the state so they track it exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q    <= OCIOSO;
            resultado_q <= '0;
            cnt_q       <= '0;
            vai_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (estado_q)
                OCIOSO: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    if (bus.start) begin
                        resultado_q <= bus.dado;
                        cnt_q       <= bus.qtd;
                        vai_q       <= 1'b0;
                        busy_q      <= 1'b1;
                        if (bus.qtd != '0) begin
                            estado_q <= DESLOCANDO;
                        end else begin
                            estado_q <= PRONTO;
                            done_q   <= 1'b1;
                        end
                    end
                end
                DESLOCANDO: begin
                    resultado_q <= desl_d;
                    vai_q       <= bit_fora_d;
                    // Guard keeps cnt from wrapping below zero.
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - LARG_QTD'(1);
                    end
                    if (cnt_q <= LARG_QTD'(1)) begin
                        estado_q <= PRONTO;
                        done_q   <= 1'b1;
                    end
                end
                PRONTO: begin
                    estado_q <= OCIOSO;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b0;
                end
                default: begin
                    estado_q <= OCIOSO;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.resultado = resultado_q;
    assign bus.vai       = vai_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_desloca_esq_seq8.sv
// Directed bench for desloca_esq_seq8 with a result scoreboard.
module tb_desloca_esq_seq8;

    typedef struct {
        logic [7:0] res;
        logic       vai;
        int         lat;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    exp_t sb[$];
    exp_t ult;

    desloca_esq_seq8_if bus ();

    desloca_esq_seq8 #(.LARGURA(8), .LARG_QTD(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t modelo(input logic [7:0] d, input int q);
        exp_t e;
        e.res = d << q;
        e.vai = (q == 0) ? 1'b0 : d[8 - q];
        e.lat = q;
        return e;
    endfunction

    // Drives one accepted request, then scrambles the inputs so a design
    // that keeps sampling dado/qtd would be caught.
    task automatic start_op(input logic [7:0] d, input logic [2:0] q);
        bus.start = 1'b1;
        bus.dado  = d;
        bus.qtd   = q;
        sb.push_back(modelo(d, int'(q)));
        tick();
        bus.start = 1'b0;
        bus.dado  = ~d;
        bus.qtd   = ~q;
        chk("busy_after_accept", 32'(bus.busy), 32'd1);
    endtask

    // k0 = edges already elapsed since acceptance.
    task automatic wait_done(input string tag, input int k0);
        int k;
        k = k0;
        while (bus.done !== 1'b1 && k < 40) begin
            tick();
            k++;
        end
        chk({tag, "_done_seen"}, 32'(bus.done), 32'd1);
        if (sb.size() == 0) begin
            chk({tag, "_scoreboard_empty"}, 32'd0, 32'd1);
        end else begin
            ult = sb.pop_front();
            chk({tag, "_latency"}, 32'(k), 32'(ult.lat));
            chk({tag, "_resultado"}, 32'(bus.resultado), 32'(ult.res));
            chk({tag, "_vai"}, 32'(bus.vai), 32'(ult.vai));
            chk({tag, "_busy_in_pronto"}, 32'(bus.busy), 32'd1);
        end
    endtask

    task automatic post_done(input string tag);
        tick();
        chk({tag, "_done_low"}, 32'(bus.done), 32'd0);
        chk({tag, "_busy_low"}, 32'(bus.busy), 32'd0);
        chk({tag, "_hold_res"}, 32'(bus.resultado), 32'(ult.res));
        chk({tag, "_hold_vai"}, 32'(bus.vai), 32'(ult.vai));
    endtask

    initial begin
        logic [7:0] rd;
        logic [2:0] rq;
        n_cmp     = 0;
        n_err     = 0;
        rst_n     = 1'b1;
        bus.start = 1'b0;
        bus.dado  = 8'h00;
        bus.qtd   = 3'd0;

        #2 rst_n = 1'b0;
        #1;
        chk("rst_resultado", 32'(bus.resultado), 32'd0);
        chk("rst_vai", 32'(bus.vai), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // 1011_0011 << 3
        start_op(8'b1011_0011, 3'd3);
        wait_done("q3", 0);
        post_done("q3");
        tick();
        chk("q3_hold_idle", 32'(bus.resultado), 32'h98);

        // qtd=0: straight to PRONTO
        start_op(8'hA5, 3'd0);
        wait_done("q0", 0);
        post_done("q0");

        // full-width shift
        start_op(8'hFF, 3'd7);
        wait_done("q7", 0);
        post_done("q7");

        // starts while busy and in PRONTO are ignored
        start_op(8'h01, 3'd5);
        tick();
        bus.start = 1'b1;
        bus.dado  = 8'hFF;
        bus.qtd   = 3'd3;
        tick();
        bus.start = 1'b0;
        chk("restart_busy", 32'(bus.busy), 32'd1);
        wait_done("restart", 2);
        bus.start = 1'b1;
        bus.dado  = 8'hFF;
        bus.qtd   = 3'd2;
        post_done("restart_pronto");
        start_op(8'hFF, 3'd2);
        wait_done("restart_next", 0);
        post_done("restart_next");

        // reset in the middle of a qtd=6 run
        start_op(8'h5A, 3'd6);
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_resultado", 32'(bus.resultado), 32'd0);
        chk("midrst_vai", 32'(bus.vai), 32'd0);
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_done", 32'(bus.done), 32'd0);
        void'(sb.pop_front());
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("midrst_no_done", 32'(bus.done), 32'd0);
        end
        chk("midrst_idle_busy", 32'(bus.busy), 32'd0);
        start_op(8'h03, 3'd1);
        wait_done("after_rst", 0);
        post_done("after_rst");

        for (int i = 0; i < 8; i++) begin
            rd = 8'($urandom);
            rq = 3'($urandom_range(0, 7));
            start_op(rd, rq);
            wait_done("rand", 0);
            post_done("rand");
            repeat ($urandom_range(0, 2)) tick();
        end

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
